ps2_keyboard_rx: RTL and testbench

//  PS/2 keyboard receiver feeding the CPU read mux at keyboard address 12'h224 and interrupt line IRQ5.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/kbd_fifo.sv | 48 ++++
 rtl/ps2_keyboard_rx.sv | 178 +++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and dout bit positions for the PS/2 keyboard receiver
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam int DOUT_VALID = 15;
  localparam int DOUT_OVF   = 14;
  localparam int DOUT_ERR   = 13;
  localparam int DOUT_BRK   = 8;

  typedef struct packed {
    logic       brk;
    logic [7:0] code;
  } kbd_entry_t;

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - synchronous scan-code FIFO; a push into a full FIFO succeeds only alongside a pop
module kbd_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  kbd_entry_t din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output kbd_entry_t head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  kbd_entry_t     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_pop;
  logic           do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver: sync, ps2c filter, deframer, scan-code FIFO
// Optional PS2_BREAK_MERGE_EN folds an F0 prefix into the brk flag of the following code.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_50_mhz,
  input  logic        reset,
  input  logic        ps2c,
  input  logic        ps2d,
  input  logic        ack,
  output logic [15:0] dout,
  output logic        IRQ_key
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]  c_sync, d_sync;
  logic        c_filt, fall_evt, d_bit;
  logic [FW-1:0] f_cnt;

  ps2_state_t  state_q, state_d;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        par_q;
  logic [TW-1:0] tmo_q;
  logic        frame_good, frame_bad, abort;

  logic        push_q, overflow, frame_err, pop, full, empty;
  kbd_entry_t  push_entry, head;

  // Synchronisers and ps2c filter reset to the idle-high level so reset never fakes an edge.
  always_ff @(posedge clk_50_mhz) begin
    if (reset) begin
      c_sync   <= 2'b11;
      d_sync   <= 2'b11;
      c_filt   <= 1'b1;
      f_cnt    <= '0;
      fall_evt <= 1'b0;
      d_bit    <= 1'b1;
    end else begin
      c_sync   <= {c_sync[0], ps2c};
      d_sync   <= {d_sync[0], ps2d};
      fall_evt <= 1'b0;
      if (c_sync[1] == c_filt) begin
        f_cnt <= '0;
      end else if (f_cnt == FW'(FILTER_LEN - 1)) begin
        c_filt   <= c_sync[1];
        f_cnt    <= '0;
        fall_evt <= c_filt;
        d_bit    <= d_sync[1];
      end else begin
        f_cnt <= f_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    abort      = 1'b0;
    if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      abort   = 1'b1;
      state_d = IDLE;
    end else if (fall_evt) begin
      case (state_q)
        IDLE:    if (!d_bit) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (d_bit && (^{shreg, par_q})) frame_good = 1'b1;
          else                            frame_bad  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50_mhz) begin
    if (reset) begin
      state_q <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fall_evt || state_q == IDLE) tmo_q <= '0;
      else                             tmo_q <= tmo_q + 1'b1;
      if (fall_evt) begin
        case (state_q)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shreg   <= {d_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par_q <= d_bit;
          default: ;
        endcase
      end
    end
  end

  assign pop = ack && !empty;

`ifdef PS2_BREAK_MERGE_EN
  logic brk_pend;
`endif

  always_ff @(posedge clk_50_mhz) begin
    if (reset) begin
      push_q     <= 1'b0;
      push_entry <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_BREAK_MERGE_EN
      brk_pend   <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
`ifdef PS2_BREAK_MERGE_EN
      if (frame_good) begin
        if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          push_q     <= 1'b1;
          push_entry <= '{brk: brk_pend, code: shreg};
          brk_pend   <= 1'b0;
        end
      end
      if (frame_bad || abort) brk_pend <= 1'b0;
`else
      if (frame_good) begin
        push_q     <= 1'b1;
        push_entry <= '{brk: 1'b0, code: shreg};
      end
`endif
      // A pop clears the sticky flags; a same-cycle new error still wins.
      if (pop) begin
        overflow  <= 1'b0;
        frame_err <= 1'b0;
      end
      if (frame_bad || abort)        frame_err <= 1'b1;
      if (push_q && full && !pop)    overflow  <= 1'b1;
    end
  end

  kbd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_50_mhz),
    .reset (reset),
    .push  (push_q),
    .din   (push_entry),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_comb begin
    dout           = '0;
    dout[DOUT_OVF] = overflow;
    dout[DOUT_ERR] = frame_err;
    if (!empty) begin
      dout[DOUT_VALID] = 1'b1;
      dout[DOUT_BRK]   = head.brk;
      dout[7:0]        = head.code;
    end
  end

  assign IRQ_key = !empty;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - randomized PS/2 frame stimulus against a queue-based keyboard model
module tb_ps2_keyboard_rx;

  localparam int DEPTH = 8;
  localparam int FLT   = 8;
  localparam int TMO   = 2000;
  localparam int HALF  = 25;

  logic        clk = 1'b0;
  logic        reset, ps2c, ps2d, ack;
  logic [15:0] dout;
  logic        irq;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_50_mhz (clk),
    .reset      (reset),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .ack        (ack),
    .dout       (dout),
    .IRQ_key    (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] model_q[$];
  bit m_ovf, m_err, m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_dout();
    if (model_q.size() == 0) return {1'b0, m_ovf, m_err, 13'b0};
    return {1'b1, m_ovf, m_err, 4'b0, model_q[0]};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input bit b);
    ps2d = b;
    wait_clks(HALF);
    ps2c = 1'b0;
    wait_clks(HALF);
    ps2c = 1'b1;
  endtask

  task automatic model_push(input logic [7:0] code);
    if (model_q.size() == DEPTH) m_ovf = 1'b1;
    else model_q.push_back({m_pend, code});
    m_pend = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad);
    logic [10:0] fr;
    int lat;
    bit was_empty;
    fr = {1'b1, (~^code) ^ bad, code, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
    ps2d = 1'b1;
    wait_clks(HALF);
    ps2c = 1'b0;
    lat = -1;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (lat < 0 && dout[15]) lat = i;
    end
    ps2c = 1'b1;
    was_empty = (model_q.size() == 0);
    if (bad) begin
      m_err  = 1'b1;
      m_pend = 1'b0;
    end else begin
`ifdef PS2_BREAK_MERGE_EN
      if (code == 8'hF0) m_pend = 1'b1;
      else model_push(code);
`else
      model_push(code);
`endif
    end
    // 2 synchroniser + FLT filter cycles to the filtered edge, then at most 2 more to valid
    if (was_empty && model_q.size() != 0)
      check("stop_latency", (lat > 0 && lat <= 2 + FLT + 2), 1);
    wait_clks(HALF);
    check("frame_dout", dout, exp_dout());
    check("frame_irq", irq, model_q.size() != 0);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    if (model_q.size() != 0) begin
      void'(model_q.pop_front());
      m_ovf = 1'b0;
      m_err = 1'b0;
    end
    check("ack_dout", dout, exp_dout());
    check("ack_irq", irq, model_q.size() != 0);
  endtask

  task automatic clear_model();
    model_q.delete();
    m_ovf = 1'b0; m_err = 1'b0; m_pend = 1'b0;
  endtask

  logic [7:0] c;

  initial begin
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; ack = 1'b0;
    clear_model();
    wait_clks(5);
    reset = 1'b0;
    wait_clks(2);
    check("reset_dout", dout, 16'h0000);
    check("reset_irq", irq, 0);

    send_frame(8'h1C, 0);
    check("good_1c", dout, 16'h801C);
    do_ack();
    check("good_1c_acked", dout, 16'h0000);

    send_frame(8'h1C, 1);
    send_frame(8'h32, 0);
    check("err_then_32", dout, 16'hA032);
    do_ack();
    check("err_cleared", dout, 16'h0000);

    for (int i = 0; i < DEPTH + 1; i++) begin
      c = 8'($urandom_range(0, 255));
      if (c == 8'hF0) c = 8'hF1;
      send_frame(c, 0);
    end
    check("overflow_set", dout[14], 1);
    for (int i = 0; i < DEPTH; i++) begin
      do_ack();
      if (i == 0) check("overflow_cleared", dout[14], 0);
    end

    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'($urandom_range(0, 1)));
    ps2d = 1'b1;
    wait_clks(TMO + 50);
    m_err = 1'b1; m_pend = 1'b0;
    check("timeout_err", dout, 16'h2000);
    send_frame(8'h29, 0);
    check("after_timeout", dout, 16'hA029);
    do_ack();

    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
`ifdef PS2_BREAK_MERGE_EN
    check("break_merged", dout, 16'h811C);
    do_ack();
    check("break_single", dout, 16'h0000);
`else
    check("break_f0", dout, 16'h80F0);
    do_ack();
    check("break_1c", dout, 16'h801C);
    do_ack();
`endif

    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(1, 127)), 0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    ps2d = 1'b1;
    reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    check("midframe_reset_dout", dout, 16'h0000);
    check("midframe_reset_irq", irq, 0);
    send_frame(8'h5A, 0);
    do_ack();

    ps2d = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ps2c = 1'b0;
      wait_clks(3);
      ps2c = 1'b1;
      wait_clks(20);
    end
    ps2d = 1'b1;
    check("glitch_idle", dout, exp_dout());
    send_frame(8'h6B, 0);
    do_ack();

    for (int i = 0; i < 30; i++) begin
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) do_ack();
    end
    for (int i = 0; i < DEPTH + 1; i++) do_ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
